stream_mux_rr: RTL and testbench
================================

# stream_mux_rr

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes, a built-in round-robin or fixed-priority arbiter, and one registered output stage. It generalises the existing combinational `mux_2_1`/`mux_4_1` to any channel count and data width. Selection is driven by requester state rather than an external select line. It sits wherever several producers share one consumer, such as memory-port or writeback-bus sharing.

## Interface
- `WIDTH`, 32, data width per channel.
- `CHANNELS`, 4, number of input channels; ≥2.
- `SEL_W`, `$clog2(CHANNELS)`, channel-index width; derived, not overridden.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  `[CHANNELS][WIDTH]`  per-channel payload.
- `in_valid`  in  `CHANNELS`  per-channel request.
- `in_ready`  out  `CHANNELS`  per-channel accept; at most one bit high.
- `prio_mode`  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- `out_data`  out  `WIDTH`  registered selected payload.
- `out_channel`  out  `SEL_W`  index of the channel that supplied `out_data`.
- `out_valid`  out  1  output register holds data.
- `out_ready`  in  1  consumer accept.

## Operation
- `load_en` = `!out_valid || out_ready`. The register is empty, or it drains this cycle.
- Request vector = `in_valid` when `load_en` is high; otherwise all zero.
- The arbiter picks one grant from the request vector. `in_ready[grant]` = 1; all other `in_ready` bits = 0.
- Transfer occurs on input `g` when `in_valid[g] && in_ready[g]`.
- On a transfer, at the next edge:
  - `out_data` ← `in_data[g]`
  - `out_channel` ← `g`
  - `out_valid` ← 1
  - `last_grant` ← `g`
- Drain with no new transfer: `out_valid` ← 0. `out_data` and `out_channel` keep their last values.
- Simultaneous drain and load: the register is overwritten and `out_valid` stays 1. No bubble is inserted.
- Round-robin mode: the search starts at `last_grant+1`, wraps modulo `CHANNELS`, and picks the first requester. Wrap-around from `CHANNELS-1` goes to 0.
- Fixed-priority mode: the lowest-index requester wins. `last_grant` still updates.
- `prio_mode` is sampled combinationally each cycle. A change takes effect on the next arbitration decision, and a held output is never altered.
- Stability: while `out_valid && !out_ready`, `out_data` and `out_channel` are held constant.
- Reset values:
  - `out_valid` = 0
  - `out_data` = 0
  - `out_channel` = 0
  - `last_grant` = `CHANNELS-1`, so channel 0 wins first in round-robin
- `in_ready` is forced to all-zero while `rst_n` is low.
- Reset mid-operation: the held output is discarded immediately. Arbitration restarts from the reset pointer.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 transfer/cycle while `out_ready` is held high.
- Combinational paths:
  - `in_valid` → `in_ready`
  - `out_ready` → `in_ready`
  - `prio_mode` → `in_ready`
- No path from `in_data` to any output except through the register.
- Fairness: in round-robin mode with all channels requesting, a channel waits at most `CHANNELS-1` transfers.
- No starvation guarantee exists in fixed mode.

## Structure
- Package `mux_pkg` holds:
  - typedef enum logic `prio_mode_t` {`PRIO_RR`=0, `PRIO_FIXED`=1}
  - a function `next_rr_index(req, last)` shared with future arbiters
- Sub-module `rr_arbiter #(CHANNELS)`:
  - inputs: `req`, `last_grant`, `prio_mode`
  - outputs: one-hot `grant`, `grant_idx`, `any_grant`
  - purely combinational
- The top level owns the output register and the `last_grant` register.

## Test plan
- Reset: drive `rst_n`=0 with `in_valid`=4'b1111. Required: `in_ready`=0, `out_valid`=0, `out_data`=0, `out_channel`=0. Release reset, then the first grant goes to channel 0.
- Single requester: `in_valid`=4'b0100, `in_data[2]`=32'hDEADBEEF, `out_ready`=1. Required: `in_ready`=4'b0100 in the same cycle. Next cycle: `out_valid`=1, `out_data`=32'hDEADBEEF, `out_channel`=2.
- Round-robin fairness: all 4 channels valid continuously, `prio_mode`=0, `out_ready`=1. Required: `out_channel` sequence 0,1,2,3,0,1 with `out_valid` high every cycle.
- Fixed priority: all 4 channels valid, `prio_mode`=1. Required: `out_channel`=0 every cycle and `in_ready`=4'b0001. Clear `in_valid[0]`, then `out_channel`=1.
- Backpressure: load channel 0, then hold `out_ready`=0 for 5 cycles with all channels valid. Required: `out_data` and `out_channel`=0 held, `in_ready`=4'b0000 throughout. Release `out_ready`; the next grant is channel 1.
- Reset mid-stream plus random soak:
  - Assert `rst_n` while `out_valid`=1. Required: `out_valid` drops to 0 without waiting for a clock edge.
  - Then run 1000 random cycles of `in_valid`, `in_data`, `out_ready` and `prio_mode` against a scoreboard. Required: every accepted word appears exactly once, in order, with the correct `out_channel`.

Source files
------------

// File: rtl/mux_pkg.sv
`timescale 1ns/1ps
// mux_pkg
// Shared types and helpers for the streaming multiplexer family.
//   prio_mode_t    : arbitration policy (round-robin / fixed lowest-index)
//   MAX_CH         : largest channel count the shared helpers support
//   MAX_SEL_W      : index width matching MAX_CH
//   next_rr_index  : round-robin search starting after the previous winner
package mux_pkg;

    typedef enum logic {
        PRIO_RR    = 1'b0,
        PRIO_FIXED = 1'b1
    } prio_mode_t;

    localparam int MAX_CH    = 64;
    localparam int MAX_SEL_W = 6;

    // Returns the first set bit of req at or after last+1, wrapping modulo n.
    // Callers zero-extend their request vector and index into the MAX_* widths.
    // With no request set the previous index is returned unchanged.
    function automatic logic [MAX_SEL_W-1:0] next_rr_index(
        input logic [MAX_CH-1:0]    req,
        input logic [MAX_SEL_W-1:0] last,
        input int                   n
    );
        logic [MAX_SEL_W-1:0] idx;
        logic                 found;
        int                   cand;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= MAX_CH; k++) begin
            cand = (int'(last) + k) % n;
            if (k <= n && !found && req[MAX_SEL_W'(cand)]) begin
                idx   = MAX_SEL_W'(cand);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
`timescale 1ns/1ps
// rr_arbiter
// Purely combinational N-way arbiter, round-robin or fixed lowest-index.
// Ports:
//   req        in  [CHANNELS]  request vector
//   last_grant in  [SEL_W]     index of the previous winner (round-robin pointer)
//   prio_mode  in  prio_mode_t policy select
//   grant      out [CHANNELS]  one-hot grant, all zero when nothing requests
//   grant_idx  out [SEL_W]     index of the granted channel (0 when none)
//   any_grant  out 1           some channel is granted
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    last_grant,
    input  prio_mode_t          prio_mode,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                any_grant
);

    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_fixed_idx;

    assign w_rr_idx = SEL_W'(next_rr_index(MAX_CH'(req), MAX_SEL_W'(last_grant), CHANNELS));

    // Scan from the top down so the lowest requesting index is written last.
    always_comb begin
        w_fixed_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_fixed_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        any_grant = |req;
        grant_idx = '0;
        grant     = '0;
        if (any_grant) begin
            grant_idx = (prio_mode == PRIO_FIXED) ? w_fixed_idx : w_rr_idx;
            grant     = CHANNELS'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
`timescale 1ns/1ps
// stream_mux_rr
// N-to-1 valid/ready stream multiplexer with a built-in arbiter and one
// registered output stage.
// Ports:
//   clk         in  1                  rising-edge clock
//   rst_n       in  1                  asynchronous active-low reset
//   in_data     in  [CHANNELS][WIDTH]  per-channel payload
//   in_valid    in  [CHANNELS]         per-channel request
//   in_ready    out [CHANNELS]         per-channel accept, at most one bit high
//   prio_mode   in  1                  0 = round-robin, 1 = fixed (lowest index)
//   out_data    out [WIDTH]            registered selected payload
//   out_channel out [SEL_W]            channel that supplied out_data
//   out_valid   out 1                  output register holds data
//   out_ready   in  1                  consumer accept
//
// Handshake: a word moves on any interface on a clock edge where valid and
// ready are both high; valid never depends on ready on the producing side,
// and in_ready here is a combinational function of in_valid, out_ready,
// out_valid, prio_mode and the round-robin pointer.
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CHANNELS-1:0][WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    input  logic                           prio_mode,
    output logic [WIDTH-1:0]               out_data,
    output logic [SEL_W-1:0]               out_channel,
    output logic                           out_valid,
    input  logic                           out_ready
);

    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_channel;
    logic                r_out_valid;
    logic [SEL_W-1:0]    r_last_grant;

    logic                w_load_en;
    logic [CHANNELS-1:0] w_req;
    logic [CHANNELS-1:0] w_grant;
    logic [SEL_W-1:0]    w_grant_idx;
    logic                w_any_grant;
    logic [WIDTH-1:0]    w_sel_data;

    // The register can take a new word when it is empty or draining now.
    assign w_load_en = !r_out_valid || out_ready;
    assign w_req     = w_load_en ? in_valid : '0;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arb (
        .req        (w_req),
        .last_grant (r_last_grant),
        .prio_mode  (prio_mode_t'(prio_mode)),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .any_grant  (w_any_grant)
    );

    // Grants only go to requesting channels, so any grant is a transfer.
    assign in_ready   = rst_n ? w_grant : '0;
    assign w_sel_data = in_data[w_grant_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_channel <= '0;
            // Pointer at the top channel so channel 0 wins first.
            r_last_grant  <= SEL_W'(CHANNELS - 1);
        end else if (w_any_grant) begin
            r_out_valid   <= 1'b1;
            r_out_data    <= w_sel_data;
            r_out_channel <= w_grant_idx;
            r_last_grant  <= w_grant_idx;
        end else if (out_ready) begin
            // Drained with nothing behind it: payload is kept, only valid drops.
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_channel = r_out_channel;

endmodule

// File: tb/tb_stream_mux_rr.sv
`timescale 1ns/1ps
module tb_stream_mux_rr;

  localparam int WIDTH    = 32;
  localparam int CHANNELS = 4;
  localparam int SEL_W    = 2;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CHANNELS-1:0][WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS-1:0]            in_ready;
  logic                           prio_mode;
  logic [WIDTH-1:0]               out_data;
  logic [SEL_W-1:0]               out_channel;
  logic                           out_valid;
  logic                           out_ready;

  stream_mux_rr #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .prio_mode   (prio_mode),
    .out_data    (out_data),
    .out_channel (out_channel),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: reference arbiter + expected {channel, data} queue
  logic [SEL_W+WIDTH-1:0] exp_q[$];
  logic m_valid = 1'b0;
  int   m_last  = CHANNELS - 1;

  always @(negedge clk) begin
    logic                   load;
    logic [CHANNELS-1:0]    eg;
    logic [SEL_W+WIDTH-1:0] item;
    int                     g;
    int                     c;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_last  = CHANNELS - 1;
      exp_q.delete();
    end else begin
      load = !m_valid || out_ready;
      eg   = '0;
      g    = -1;
      if (load && in_valid != '0) begin
        if (prio_mode) begin
          for (int i = 0; i < CHANNELS; i++)
            if (g < 0 && in_valid[SEL_W'(i)]) g = i;
        end else begin
          for (int k = 1; k <= CHANNELS; k++) begin
            c = (m_last + k) % CHANNELS;
            if (g < 0 && in_valid[SEL_W'(c)]) g = c;
          end
        end
        eg = CHANNELS'(1) << g;
      end
      check("sb_in_ready", 64'(in_ready), 64'(eg));
      check("sb_out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_queue_nonempty", 64'(0), 64'(1));
        end else begin
          item = exp_q.pop_front();
          check("sb_out_word", 64'({out_channel, out_data}), 64'(item));
        end
      end
      if (g >= 0) begin
        exp_q.push_back({SEL_W'(g), in_data[SEL_W'(g)]});
        m_last  = g;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // directed vector table
  typedef struct {
    logic [CHANNELS-1:0] v;
    logic                prio;
    logic                ordy;
    logic [CHANNELS-1:0] exp_rdy;
    logic                exp_ov;
    logic [SEL_W-1:0]    exp_ch;
    logic [WIDTH-1:0]    exp_d;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [WIDTH-1:0] dval(input logic [SEL_W-1:0] ch);
    case (ch)
      2'd0:    return 32'hA000_0000;
      2'd1:    return 32'hA000_0001;
      2'd2:    return 32'hDEAD_BEEF;
      default: return 32'hA000_0003;
    endcase
  endfunction

  task automatic add(input logic [3:0] v, input logic p, input logic o,
                     input logic [3:0] r, input logic ov, input logic [1:0] ch);
    vec_t e;
    e.v = v; e.prio = p; e.ordy = o; e.exp_rdy = r;
    e.exp_ov = ov; e.exp_ch = ch; e.exp_d = dval(ch);
    tbl.push_back(e);
  endtask

  task automatic set_fixed_data();
    for (int i = 0; i < CHANNELS; i++) in_data[i] = dval(SEL_W'(i));
  endtask

  initial begin
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    prio_mode = 1'b0;
    set_fixed_data();

    // reset state with all channels requesting
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_channel", 64'(out_channel), 64'(0));
    rst_n = 1'b1;

    //   valid    prio  ordy  rdy     ov  ch
    add(4'b1111, 0, 1, 4'b0001, 1, 0);   // first grant after reset
    add(4'b0100, 0, 1, 4'b0100, 1, 2);   // single requester
    add(4'b1111, 0, 1, 4'b1000, 1, 3);   // round-robin rotation
    add(4'b1111, 0, 1, 4'b0001, 1, 0);   // wrap 3 -> 0
    add(4'b1111, 0, 1, 4'b0010, 1, 1);
    add(4'b1111, 0, 1, 4'b0100, 1, 2);
    add(4'b1111, 0, 1, 4'b1000, 1, 3);
    add(4'b1111, 0, 1, 4'b0001, 1, 0);
    add(4'b1111, 0, 1, 4'b0010, 1, 1);
    add(4'b1111, 1, 1, 4'b0001, 1, 0);   // fixed priority
    add(4'b1111, 1, 1, 4'b0001, 1, 0);
    add(4'b1111, 1, 1, 4'b0001, 1, 0);
    add(4'b1110, 1, 1, 4'b0010, 1, 1);   // channel 0 drops out
    add(4'b0001, 0, 1, 4'b0001, 1, 0);   // load channel 0
    add(4'b1111, 0, 0, 4'b0000, 1, 0);   // backpressure: held
    add(4'b1111, 0, 0, 4'b0000, 1, 0);
    add(4'b1111, 0, 0, 4'b0000, 1, 0);
    add(4'b1111, 1, 0, 4'b0000, 1, 0);   // mode flip while held
    add(4'b1111, 1, 0, 4'b0000, 1, 0);
    add(4'b1111, 0, 1, 4'b0010, 1, 1);   // release: next after 0
    add(4'b0000, 0, 1, 4'b0000, 0, 1);   // drain, payload kept

    for (int i = 0; i < tbl.size(); i++) begin
      in_valid  = tbl[i].v;
      prio_mode = tbl[i].prio;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      check($sformatf("vec%0d_out_channel", i), 64'(out_channel), 64'(tbl[i].exp_ch));
      check($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(tbl[i].exp_d));
    end

    // reset while the output register is full and stalled
    in_valid  = 4'b0010;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_out_data", 64'(out_data), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_first_grant", 64'(in_ready), 64'(4'b0001));

    // random soak, checked by the scoreboard
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk);
      #1;
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) prio_mode = ~prio_mode;
      for (int i = 0; i < CHANNELS; i++) in_data[i] = $urandom;
    end

    // drain: everything accepted must have come out
    @(posedge clk);
    #1;
    in_valid  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'(0));
    check("final_out_valid", 64'(out_valid), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
